// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants.
// Used by the write-back stage and the load aligner.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic            valid;
        logic            reg_wen;
        logic [4:0]      rd;
        wb_sel_e         wb_sel;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] load_data;
        logic [2:0]      funct3;
    } mem_wb_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM -> WB bundle plus the register-file write port.
// master is the MEM side, slave is the write-back stage.
interface writeback_stage_if;
    import riscv_pkg::*;

    logic            mem_valid;
    logic            mem_reg_wen;
    logic [4:0]      mem_rd;
    logic [1:0]      mem_wb_sel;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_pc_plus4;
    logic [XLEN-1:0] mem_load_data;
    logic [2:0]      mem_funct3;

    logic            RegWEn;
    logic [4:0]      AddrD;
    logic [XLEN-1:0] DataD;
    logic            wb_valid;
    logic            wb_err;

    modport master (
        output mem_valid, mem_reg_wen, mem_rd, mem_wb_sel,
        output mem_alu_result, mem_pc_plus4, mem_load_data, mem_funct3,
        input  RegWEn, AddrD, DataD, wb_valid, wb_err
    );

    modport slave (
        input  mem_valid, mem_reg_wen, mem_rd, mem_wb_sel,
        input  mem_alu_result, mem_pc_plus4, mem_load_data, mem_funct3,
        output RegWEn, AddrD, DataD, wb_valid, wb_err
    );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Extracts and extends a byte/half/word from an aligned memory word.
// Flags misaligned offsets and funct3 codes that are not loads.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned,
    output logic            illegal
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;

    // Pick the addressed lane, then extend per funct3
    always_comb begin
        shifted    = word >> {offset, 3'b000};
        byte_v     = shifted[7:0];
        half_v     = offset[1] ? word[31:16] : word[15:0];
        data       = word;
        misaligned = 1'b0;
        illegal    = 1'b0;
        unique case (funct3)
            F3_LB:  data = {{24{byte_v[7]}}, byte_v};
            F3_LBU: data = {24'h0, byte_v};
            F3_LH: begin
                data       = {{16{half_v[15]}}, half_v};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {16'h0, half_v};
                misaligned = offset[0];
            end
            F3_LW:  misaligned = |offset;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// RV32I write-back stage: MEM/WB register, result mux,
// register-file write enable and retired-instruction counter.
module writeback_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    writeback_stage_if.slave  bus,
    output logic [63:0]       instret
);

    mem_wb_t         r;
    logic            done;
    logic [XLEN-1:0] ld_data;
    logic            ld_mis;
    logic            ld_ill;
    logic            err;
    logic            first;
    logic [XLEN-1:0] wdata;

    load_align u_align (
        .word       (r.load_data),
        .offset     (r.alu_result[1:0]),
        .funct3     (r.funct3),
        .data       (ld_data),
        .misaligned (ld_mis),
        .illegal    (ld_ill)
    );

    // MEM/WB register: flush beats stall beats load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            done <= 1'b0;
        end else if (flush) begin
            r.valid   <= 1'b0;
            r.reg_wen <= 1'b0;
            done      <= 1'b0;
        end else if (stall) begin
            done <= r.valid;
        end else begin
            r.valid      <= bus.mem_valid;
            r.reg_wen    <= bus.mem_reg_wen;
            r.rd         <= bus.mem_rd;
            r.wb_sel     <= wb_sel_e'(bus.mem_wb_sel);
            r.alu_result <= bus.mem_alu_result;
            r.pc_plus4   <= bus.mem_pc_plus4;
            r.load_data  <= bus.mem_load_data;
            r.funct3     <= bus.mem_funct3;
            done         <= 1'b0;
        end
    end

    // Result select and error detection
    always_comb begin
        wdata = r.alu_result;
        err   = 1'b0;
        unique case (r.wb_sel)
            WB_ALU:  wdata = r.alu_result;
            WB_LOAD: begin
                wdata = ld_data;
                err   = ld_mis | ld_ill;
            end
            WB_PC4:  wdata = r.pc_plus4;
            WB_RSVD: err = 1'b1;
        endcase
    end

    assign first        = r.valid & ~done;
    assign bus.RegWEn   = first & r.reg_wen & (|r.rd) & ~err;
    assign bus.AddrD    = r.rd;
    assign bus.DataD    = wdata;
    assign bus.wb_valid = r.valid;
    assign bus.wb_err   = first & err;

    // Count each instruction once, on its first WB cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= 64'd0;
        else if (first)
            instret <= instret + 64'd1;
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
// Each task drives one scenario and checks its outputs.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [63:0] instret;

    int n_cmp;
    int n_bad;
    logic [63:0] exp_ir;

    logic [2:0]  ld_f3  [8];
    logic [1:0]  ld_off [8];
    logic [31:0] ld_exp [8];

    writeback_stage_if bus ();

    writeback_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .flush   (flush),
        .bus     (bus),
        .instret (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic w,
                         input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] ld, input logic [2:0] f3);
        bus.mem_valid      = v;
        bus.mem_reg_wen    = w;
        bus.mem_rd         = rd;
        bus.mem_wb_sel     = sel;
        bus.mem_alu_result = alu;
        bus.mem_pc_plus4   = pc4;
        bus.mem_load_data  = ld;
        bus.mem_funct3     = f3;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        idle();
        #12;
        n_cmp++;
        if (bus.RegWEn !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_regwen: got %b want 0", bus.RegWEn);
        end
        n_cmp++;
        if (bus.AddrD !== 5'd0 || bus.DataD !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_addr_data: got %h/%h want 0/0",
                     bus.AddrD, bus.DataD);
        end
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.wb_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid_err: got %b/%b want 0/0",
                     bus.wb_valid, bus.wb_err);
        end
        n_cmp++;
        if (instret !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_instret: got %0d want 0", instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_ir = 64'd0;
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b1, 5'd5, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 3'd0);
        step();
        idle();
        n_cmp++;
        if (bus.RegWEn !== 1'b1 || bus.AddrD !== 5'd5
            || bus.DataD !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL alu_write: got %b/%0d/%h want 1/5/12345678",
                     bus.RegWEn, bus.AddrD, bus.DataD);
        end
        n_cmp++;
        if (instret !== 64'd0) begin
            n_bad++;
            $display("FAIL alu_instret_same: got %0d want 0", instret);
        end
        step();
        exp_ir = exp_ir + 1;
        n_cmp++;
        if (bus.RegWEn !== 1'b0 || instret !== exp_ir) begin
            n_bad++;
            $display("FAIL alu_after: got %b/%0d want 0/%0d",
                     bus.RegWEn, instret, exp_ir);
        end
    endtask

    task automatic test_loads();
        ld_f3[0] = 3'b000; ld_off[0] = 2'd0; ld_exp[0] = 32'h0000_0001;
        ld_f3[1] = 3'b000; ld_off[1] = 2'd1; ld_exp[1] = 32'h0000_007F;
        ld_f3[2] = 3'b000; ld_off[2] = 2'd2; ld_exp[2] = 32'hFFFF_FFFF;
        ld_f3[3] = 3'b000; ld_off[3] = 2'd3; ld_exp[3] = 32'hFFFF_FF80;
        ld_f3[4] = 3'b100; ld_off[4] = 2'd3; ld_exp[4] = 32'h0000_0080;
        ld_f3[5] = 3'b101; ld_off[5] = 2'd2; ld_exp[5] = 32'h0000_80FF;
        ld_f3[6] = 3'b001; ld_off[6] = 2'd2; ld_exp[6] = 32'hFFFF_80FF;
        ld_f3[7] = 3'b010; ld_off[7] = 2'd0; ld_exp[7] = 32'h80FF_7F01;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 5'd7, 2'd1, {30'h400, ld_off[i]},
                  32'h0, 32'h80FF_7F01, ld_f3[i]);
            step();
            n_cmp++;
            if (bus.DataD !== ld_exp[i] || bus.RegWEn !== 1'b1
                || bus.wb_err !== 1'b0) begin
                n_bad++;
                $display("FAIL load_%0d: got %h/%b/%b want %h/1/0",
                         i, bus.DataD, bus.RegWEn, bus.wb_err, ld_exp[i]);
            end
        end
        idle();
        step();
        exp_ir = exp_ir + 8;
        n_cmp++;
        if (instret !== exp_ir) begin
            n_bad++;
            $display("FAIL load_instret: got %0d want %0d", instret, exp_ir);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  esel [4];
        logic [2:0]  ef3  [4];
        logic [31:0] eadr [4];
        esel[0] = 2'd1; ef3[0] = 3'b010; eadr[0] = 32'h102;
        esel[1] = 2'd1; ef3[1] = 3'b110; eadr[1] = 32'h100;
        esel[2] = 2'd1; ef3[2] = 3'b001; eadr[2] = 32'h101;
        esel[3] = 2'd3; ef3[3] = 3'b000; eadr[3] = 32'h100;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd3, esel[i], eadr[i], 32'h0,
                  32'h80FF_7F01, ef3[i]);
            step();
            idle();
            n_cmp++;
            if (bus.RegWEn !== 1'b0 || bus.wb_err !== 1'b1) begin
                n_bad++;
                $display("FAIL err_%0d: got wen %b err %b want 0/1",
                         i, bus.RegWEn, bus.wb_err);
            end
            step();
            exp_ir = exp_ir + 1;
            n_cmp++;
            if (bus.wb_err !== 1'b0 || instret !== exp_ir) begin
                n_bad++;
                $display("FAIL err_after_%0d: got %b/%0d want 0/%0d",
                         i, bus.wb_err, instret, exp_ir);
            end
        end
    endtask

    task automatic test_stall();
        int hi;
        drive(1'b1, 1'b1, 5'd1, 2'd2, 32'hDEAD_0000, 32'h0000_0104,
              32'h0, 3'd0);
        step();
        idle();
        stall = 1'b1;
        n_cmp++;
        if (bus.RegWEn !== 1'b1 || bus.AddrD !== 5'd1
            || bus.DataD !== 32'h0000_0104) begin
            n_bad++;
            $display("FAIL jal_write: got %b/%0d/%h want 1/1/00000104",
                     bus.RegWEn, bus.AddrD, bus.DataD);
        end
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.RegWEn === 1'b1) hi++;
            n_cmp++;
            if (bus.wb_valid !== 1'b1 || bus.DataD !== 32'h0000_0104) begin
                n_bad++;
                $display("FAIL jal_held_%0d: got %b/%h want 1/00000104",
                         i, bus.wb_valid, bus.DataD);
            end
        end
        n_cmp++;
        if (hi !== 0) begin
            n_bad++;
            $display("FAIL jal_rewrite: got %0d extra writes want 0", hi);
        end
        exp_ir = exp_ir + 1;
        n_cmp++;
        if (instret !== exp_ir) begin
            n_bad++;
            $display("FAIL jal_instret: got %0d want %0d", instret, exp_ir);
        end
        stall = 1'b0;
        drive(1'b1, 1'b1, 5'd4, 2'd1, 32'h102, 32'h0, 32'h0, 3'b010);
        step();
        idle();
        stall = 1'b1;
        step();
        n_cmp++;
        if (bus.wb_err !== 1'b0 || bus.wb_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL err_stall_once: got err %b valid %b want 0/1",
                     bus.wb_err, bus.wb_valid);
        end
        stall = 1'b0;
        step();
        exp_ir = exp_ir + 1;
    endtask

    task automatic test_x0_flush();
        drive(1'b1, 1'b1, 5'd0, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 3'd0);
        step();
        n_cmp++;
        if (bus.RegWEn !== 1'b0 || bus.wb_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL x0_write: got wen %b valid %b want 0/1",
                     bus.RegWEn, bus.wb_valid);
        end
        drive(1'b1, 1'b1, 5'd6, 2'd0, 32'h1, 32'h0, 32'h0, 3'd0);
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        idle();
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || bus.RegWEn !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_stall: got valid %b wen %b want 0/0",
                     bus.wb_valid, bus.RegWEn);
        end
        exp_ir = exp_ir + 1;
        n_cmp++;
        if (instret !== exp_ir) begin
            n_bad++;
            $display("FAIL x0_instret: got %0d want %0d", instret, exp_ir);
        end
        step();
    endtask

    task automatic test_wrap();
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        drive(1'b1, 1'b1, 5'd8, 2'd0, 32'h55, 32'h0, 32'h0, 3'd0);
        step();
        idle();
        n_cmp++;
        if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL wrap_pre: got %h want ffffffffffffffff", instret);
        end
        step();
        exp_ir = 64'd0;
        n_cmp++;
        if (instret !== exp_ir) begin
            n_bad++;
            $display("FAIL wrap: got %h want 0", instret);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 5'd9, 2'd0, 32'hA5A5_A5A5, 32'h0, 32'h0, 3'd0);
        step();
        idle();
        stall = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.RegWEn !== 1'b0 || bus.AddrD !== 5'd0
            || bus.DataD !== 32'd0 || bus.wb_valid !== 1'b0
            || bus.wb_err !== 1'b0 || instret !== 64'd0) begin
            n_bad++;
            $display("FAIL async_rst: got %b/%0d/%h/%b/%b/%0d want all 0",
                     bus.RegWEn, bus.AddrD, bus.DataD, bus.wb_valid,
                     bus.wb_err, instret);
        end
        #2;
        rst_n = 1'b1;
        stall = 1'b0;
        step();
        n_cmp++;
        if (bus.RegWEn !== 1'b0 || bus.wb_valid !== 1'b0
            || instret !== 64'd0) begin
            n_bad++;
            $display("FAIL post_rst: got %b/%b/%0d want 0/0/0",
                     bus.RegWEn, bus.wb_valid, instret);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_alu();
        test_loads();
        test_errors();
        test_stall();
        test_x0_flush();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the RV32I five-stage pipeline: holds the MEM/WB pipeline register and selects the write-back value. Choices are ALU result, aligned and extended load data, or PC+4. Drives the register file write port and exposes the same value for forwarding. Also keeps a 64-bit retired-instruction counter.

## Interface
- No parameters. XLEN fixed at 32.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold MEM/WB register contents.
- flush  in  1  load a bubble into MEM/WB.
- mem_valid  in  1  MEM stage holds a real instruction.
- mem_reg_wen  in  1  instruction writes rd.
- mem_rd  in  5  destination register.
- mem_wb_sel  in  2  source select: 0 ALU, 1 load, 2 PC+4, 3 reserved.
- mem_alu_result  in  32  ALU result; for loads, the effective address.
- mem_pc_plus4  in  32  link value.
- mem_load_data  in  32  raw aligned word from data memory.
- mem_funct3  in  3  load width/sign code.
- RegWEn  out  1  register file write enable.
- AddrD  out  5  register file write address.
- DataD  out  32  register file write data.
- wb_valid  out  1  WB holds a real instruction.
- wb_err  out  1  one-cycle pulse on a suppressed illegal or misaligned load.
- instret  out  64  retired-instruction count.

## Operation
- MEM/WB register: on posedge, priority order is flush > stall > load.
  - flush clears valid and reg_wen.
  - stall holds all fields.
  - Otherwise all mem_* inputs are captured.
- A `done` flag is set the cycle after an instruction first occupies WB. It clears whenever a new instruction or bubble is loaded.
- While stalled, the held instruction is presented again, but its side effects happen only once.
- Write data:
  - sel 0: alu_result.
  - sel 2: pc_plus4.
  - sel 1: load_align output. The byte offset is alu_result[1:0].
- load_align by funct3:
  - 000 LB: byte[off], sign-extended.
  - 100 LBU: byte[off], zero-extended.
  - 001 LH: half[off[1]], sign-extended.
  - 101 LHU: half[off[1]], zero-extended.
  - 010 LW: whole word.
- Error cases (write suppressed, wb_err pulses):
  - LH/LHU with off[0]=1.
  - LW with off≠0.
  - funct3 011, 110 or 111 on a load.
  - sel 3.
- RegWEn = valid & reg_wen & !done & rd≠0 & !err.
- AddrD = rd. DataD = selected value; it is valid whenever wb_valid, independent of RegWEn.
- instret increments by 1 when valid & !done, including suppressed or x0 writes. It wraps modulo 2^64.

## Timing
- Reset: all MEM/WB fields, done, RegWEn, AddrD, DataD, wb_valid, wb_err and instret are 0.
- Latency: an instruction captured at edge N drives RegWEn/AddrD/DataD combinationally during cycle N. The register file commits at edge N+1.
- The register file reads asynchronously. A same-cycle read of AddrD in decode returns the old value, so the hazard unit must forward DataD.
- wb_err and the instret increment happen in the same cycle as the would-be RegWEn, exactly once per instruction.
- flush together with stall: the bubble is loaded and done is cleared.
- rst_n asserted mid-stall: state clears immediately and asynchronously; no write is issued after reset release until a new instruction is captured.
- instret at 2^64−1 followed by a retire: the counter becomes 0 with no flag.

## Structure
- riscv_pkg (shared) holds:
  - wb_sel_e enum (WB_ALU, WB_LOAD, WB_PC4, WB_RSVD).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - XLEN.
- Sub-module load_align: combinational. Inputs: word, offset, funct3. Outputs: data, misaligned, illegal. Reused later by the memory stage.
- Top level contains the pipeline register, done flag, mux, enable logic and counter.

## Test plan
- Reset release, then an ALU op with rd=5 and result 0x1234_5678 → one cycle of RegWEn=1, AddrD=5, DataD=0x12345678; instret becomes 1.
- LB with word 0x80FF_7F01 at offsets 0..3 → DataD = 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Repeat with LBU (offset 3 → 0x00000080) and LHU at offset 2 → 0x000080FF.
- LW at offset 2 → RegWEn=0, wb_err pulses once, instret increments; funct3=110 behaves the same.
- JAL with rd=1, pc_plus4 0x0000_0104, stall held 3 cycles → RegWEn high only in the first cycle; instret +1 total.
- rd=0 ALU op → RegWEn=0, instret +1. flush and stall together → wb_valid=0 next cycle.
- instret preloaded to all ones via forced retires (or a hierarchical force) → the next retire reads 0. rst_n pulsed low mid-stream → all outputs 0 asynchronously.
